// File: rtl/pcie_ingress.sv
// pcie_ingress: receive-side TLP parser. Captures the 3/4 DWORD header and
// routes CplD payload to the ingress FIFO and 1-DW memory writes to registers.
module pcie_ingress #(
   parameter logic [7:0] CPLD_TYPE  = 8'h4A,
   parameter logic [7:0] CPL_TYPE   = 8'h0A,
   parameter logic [7:0] MWR32_TYPE = 8'h40,
   parameter logic [7:0] MWR64_TYPE = 8'h60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_axi_ingress_data,
   input  logic [3:0]  i_axi_ingress_keep,
   input  logic        i_axi_ingress_last,
   input  logic        i_axi_ingress_valid,
   output logic        o_axi_ingress_ready,
   input  logic        i_fifo_rdy,
   output logic        o_fifo_act,
   input  logic [23:0] i_fifo_size,
   output logic [31:0] o_fifo_data,
   output logic        o_fifo_stb,
   output logic        o_reg_wr_stb,
   output logic [31:0] o_reg_addr,
   output logic [31:0] o_reg_data,
   output logic        o_cmpl_done,
   output logic [7:0]  o_cmpl_tag,
   output logic [2:0]  o_cmpl_status,
   output logic [11:0] o_cmpl_byte_cnt,
   output logic        o_unsupported,
   output logic        o_pkt_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_WAIT_FIFO, S_DATA, S_REG_DATA, S_DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  type_q, type_d;
   logic [9:0]  len_q, len_d;
   logic [2:0]  hsts_q, hsts_d;
   logic [11:0] hbc_q, hbc_d;
   logic [31:0] hdr2_q, hdr2_d;
   logic [31:0] hdr3_q, hdr3_d;
   logic [23:0] fifo_cnt_q, fifo_cnt_d;
   logic [10:0] data_cnt_q, data_cnt_d;
   logic        act_q, act_d;
   logic [31:0] fifo_data_q, fifo_data_d;
   logic        fifo_stb_q, fifo_stb_d;
   logic        reg_wr_q, reg_wr_d;
   logic [31:0] reg_addr_q, reg_addr_d;
   logic [31:0] reg_data_q, reg_data_d;
   logic        cmpl_done_q, cmpl_done_d;
   logic [7:0]  tag_q, tag_d;
   logic [2:0]  sts_q, sts_d;
   logic [11:0] bc_q, bc_d;
   logic        unsup_q, unsup_d;
   logic        err_q, err_d;

   logic        ready_c;
   logic        acc;
   logic [31:0] beat;
   logic        last;
   logic [1:0]  last_idx;
   logic [10:0] len_dw;
   logic [10:0] dc1;
   logic [23:0] fc1;
   logic        unused_keep;

   assign unused_keep = ^i_axi_ingress_keep;
   assign beat     = i_axi_ingress_data;
   assign last     = i_axi_ingress_last;
   assign acc      = i_axi_ingress_valid && ready_c;
   assign last_idx = type_q[5] ? 2'd3 : 2'd2;
   // a zero length field encodes 1024 DWORDs
   assign len_dw   = {~|len_q, len_q};
   assign dc1      = data_cnt_q + 11'd1;
   assign fc1      = fifo_cnt_q + 24'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         type_q      <= '0;
         len_q       <= '0;
         hsts_q      <= '0;
         hbc_q       <= '0;
         hdr2_q      <= '0;
         hdr3_q      <= '0;
         fifo_cnt_q  <= '0;
         data_cnt_q  <= '0;
         act_q       <= 1'b0;
         fifo_data_q <= '0;
         fifo_stb_q  <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_data_q  <= '0;
         cmpl_done_q <= 1'b0;
         tag_q       <= '0;
         sts_q       <= '0;
         bc_q        <= '0;
         unsup_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         type_q      <= type_d;
         len_q       <= len_d;
         hsts_q      <= hsts_d;
         hbc_q       <= hbc_d;
         hdr2_q      <= hdr2_d;
         hdr3_q      <= hdr3_d;
         fifo_cnt_q  <= fifo_cnt_d;
         data_cnt_q  <= data_cnt_d;
         act_q       <= act_d;
         fifo_data_q <= fifo_data_d;
         fifo_stb_q  <= fifo_stb_d;
         reg_wr_q    <= reg_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_data_q  <= reg_data_d;
         cmpl_done_q <= cmpl_done_d;
         tag_q       <= tag_d;
         sts_q       <= sts_d;
         bc_q        <= bc_d;
         unsup_q     <= unsup_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      type_d      = type_q;
      len_d       = len_q;
      hsts_d      = hsts_q;
      hbc_d       = hbc_q;
      hdr2_d      = hdr2_q;
      hdr3_d      = hdr3_q;
      fifo_cnt_d  = fifo_cnt_q;
      data_cnt_d  = data_cnt_q;
      act_d       = act_q;
      fifo_data_d = fifo_data_q;
      fifo_stb_d  = 1'b0;
      reg_wr_d    = 1'b0;
      reg_addr_d  = reg_addr_q;
      reg_data_d  = reg_data_q;
      cmpl_done_d = 1'b0;
      tag_d       = tag_q;
      sts_d       = sts_q;
      bc_d        = bc_q;
      unsup_d     = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (acc) begin
               type_d = beat[31:24];
               len_d  = beat[9:0];
               idx_d  = 2'd1;
               if (last) err_d = 1'b1;
               else state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (acc) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd1) begin
                  hsts_d = beat[15:13];
                  hbc_d  = beat[11:0];
               end else if (idx_q == 2'd2) begin
                  hdr2_d = beat;
               end else begin
                  hdr3_d = beat;
               end
               if (idx_q == last_idx) begin
                  // CPL is always a 3-DW header, so the tag is on this beat
                  if (type_q == CPL_TYPE) begin
                     if (last) begin
                        cmpl_done_d = 1'b1;
                        tag_d   = beat[15:8];
                        sts_d   = hsts_q;
                        bc_d    = hbc_q;
                        state_d = S_IDLE;
                     end else begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                     end
                  end else if (type_q == CPLD_TYPE) begin
                     data_cnt_d = '0;
                     state_d    = S_WAIT_FIFO;
                  end else if ((type_q == MWR32_TYPE ||
                                type_q == MWR64_TYPE) &&
                               len_q == 10'd1) begin
                     state_d = S_REG_DATA;
                  end else begin
                     unsup_d = 1'b1;
                     state_d = last ? S_IDLE : S_DRAIN;
                  end
               end else if (last) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_FIFO: begin
            if (i_fifo_rdy && !act_q) begin
               act_d      = 1'b1;
               fifo_cnt_d = '0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            if (acc) begin
               fifo_data_d = beat;
               fifo_stb_d  = 1'b1;
               fifo_cnt_d  = fc1;
               data_cnt_d  = dc1;
               if (dc1 == len_dw && last) begin
                  cmpl_done_d = 1'b1;
                  tag_d   = hdr2_q[15:8];
                  sts_d   = hsts_q;
                  bc_d    = hbc_q;
                  act_d   = 1'b0;
                  state_d = S_IDLE;
               end else if (dc1 == len_dw) begin
                  err_d   = 1'b1;
                  act_d   = 1'b0;
                  state_d = S_DRAIN;
               end else if (last) begin
                  err_d   = 1'b1;
                  act_d   = 1'b0;
                  state_d = S_IDLE;
               end else if (fc1 == i_fifo_size) begin
                  act_d   = 1'b0;
                  state_d = S_WAIT_FIFO;
               end
            end
         end
         S_REG_DATA: begin
            if (acc) begin
               reg_addr_d = type_q[5] ? hdr3_q : hdr2_q;
               reg_data_d = beat;
               reg_wr_d   = 1'b1;
               if (!last) begin
                  err_d   = 1'b1;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            if (acc && last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready_c = 1'b0;
      unique case (state_q)
         S_IDLE, S_HDR, S_REG_DATA, S_DRAIN: ready_c = 1'b1;
         S_DATA: ready_c = act_q && (fifo_cnt_q < i_fifo_size);
         default: ready_c = 1'b0;
      endcase
   end

   // ready is forced low while reset is held so no beat is taken
   assign o_axi_ingress_ready = ready_c & ~rst;
   assign o_fifo_act      = act_q;
   assign o_fifo_data     = fifo_data_q;
   assign o_fifo_stb      = fifo_stb_q;
   assign o_reg_wr_stb    = reg_wr_q;
   assign o_reg_addr      = reg_addr_q;
   assign o_reg_data      = reg_data_q;
   assign o_cmpl_done     = cmpl_done_q;
   assign o_cmpl_tag      = tag_q;
   assign o_cmpl_status   = sts_q;
   assign o_cmpl_byte_cnt = bc_q;
   assign o_unsupported   = unsup_q;
   assign o_pkt_error     = err_q;

endmodule

// File: tb/tb_pcie_ingress.sv
// tb_pcie_ingress: directed TLP sequences with hand-computed expectations.
`timescale 1ns/1ps
module tb_pcie_ingress;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] i_axi_ingress_data = '0;
   logic [3:0]  i_axi_ingress_keep = 4'hF;
   logic        i_axi_ingress_last = 1'b0;
   logic        i_axi_ingress_valid = 1'b0;
   logic        o_axi_ingress_ready;
   logic        i_fifo_rdy = 1'b1;
   logic        o_fifo_act;
   logic [23:0] i_fifo_size = 24'd16;
   logic [31:0] o_fifo_data;
   logic        o_fifo_stb;
   logic        o_reg_wr_stb;
   logic [31:0] o_reg_addr;
   logic [31:0] o_reg_data;
   logic        o_cmpl_done;
   logic [7:0]  o_cmpl_tag;
   logic [2:0]  o_cmpl_status;
   logic [11:0] o_cmpl_byte_cnt;
   logic        o_unsupported;
   logic        o_pkt_error;

   pcie_ingress dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_axi_ingress_data  (i_axi_ingress_data),
      .i_axi_ingress_keep  (i_axi_ingress_keep),
      .i_axi_ingress_last  (i_axi_ingress_last),
      .i_axi_ingress_valid (i_axi_ingress_valid),
      .o_axi_ingress_ready (o_axi_ingress_ready),
      .i_fifo_rdy          (i_fifo_rdy),
      .o_fifo_act          (o_fifo_act),
      .i_fifo_size         (i_fifo_size),
      .o_fifo_data         (o_fifo_data),
      .o_fifo_stb          (o_fifo_stb),
      .o_reg_wr_stb        (o_reg_wr_stb),
      .o_reg_addr          (o_reg_addr),
      .o_reg_data          (o_reg_data),
      .o_cmpl_done         (o_cmpl_done),
      .o_cmpl_tag          (o_cmpl_tag),
      .o_cmpl_status       (o_cmpl_status),
      .o_cmpl_byte_cnt     (o_cmpl_byte_cnt),
      .o_unsupported       (o_unsupported),
      .o_pkt_error         (o_pkt_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [31:0] fifo_q[$];
   int stb_n, reg_n, cmpl_n, unsup_n, err_n, act_n, act_rise, rdy_low;
   logic act_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o_fifo_stb) begin
            fifo_q.push_back(o_fifo_data);
            stb_n++;
         end
         if (o_reg_wr_stb) reg_n++;
         if (o_cmpl_done) cmpl_n++;
         if (o_unsupported) unsup_n++;
         if (o_pkt_error) err_n++;
         if (o_fifo_act) act_n++;
         if (o_fifo_act && !act_prev) act_rise++;
         if (!o_axi_ingress_ready) rdy_low++;
         act_prev = o_fifo_act;
      end
   end

   task automatic clear();
      fifo_q.delete();
      stb_n = 0; reg_n = 0; cmpl_n = 0; unsup_n = 0;
      err_n = 0; act_n = 0; act_rise = 0; rdy_low = 0;
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int n;
      @(negedge clk);
      i_axi_ingress_data  = d;
      i_axi_ingress_last  = l;
      i_axi_ingress_valid = 1'b1;
      n = 0;
      while (!o_axi_ingress_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      i_axi_ingress_valid = 1'b0;
      i_axi_ingress_last  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic cpld(input logic [7:0] tag, input logic [31:0] base,
                       input int n, input int last_at);
      send(32'h4A00_0000 | 32'(n), 1'b0);
      send(32'h0000_0000 | 32'(n * 4), 1'b0);
      send({16'h0000, tag, 8'h00}, 1'b0);
      for (int i = 0; i < last_at; i++)
         send(base + 32'(i), (i == last_at - 1));
   endtask

   task automatic check_data(input string tag, input logic [31:0] base,
                             input int n);
      check({tag, "_cnt"}, 64'(fifo_q.size()), 64'(n));
      for (int i = 0; i < n; i++)
         check(tag, (i < fifo_q.size()) ? {32'd0, fifo_q[i]} : 64'hx,
               {32'd0, base + 32'(i)});
   endtask

   initial begin
      #1;
      check("rst_ready", 64'(o_axi_ingress_ready), 64'd0);
      check("rst_act", 64'(o_fifo_act), 64'd0);
      check("rst_strobes", {59'd0, o_fifo_stb, o_reg_wr_stb, o_cmpl_done,
            o_unsupported, o_pkt_error}, 64'd0);
      check("rst_tag", 64'(o_cmpl_tag), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear();

      // CplD length 4, tag 5, roomy buffer
      cpld(8'h05, 32'hD000_0000, 4, 4);
      idle();
      check_data("t1_data", 32'hD000_0000, 4);
      check("t1_cmpl", 64'(cmpl_n), 64'd1);
      check("t1_tag", 64'(o_cmpl_tag), 64'h05);
      check("t1_status", 64'(o_cmpl_status), 64'd0);
      check("t1_bc", 64'(o_cmpl_byte_cnt), 64'd16);
      check("t1_act_cyc", 64'(act_n), 64'd4);
      check("t1_act_end", 64'(o_fifo_act), 64'd0);
      check("t1_rdy_low", 64'(rdy_low), 64'd1);
      clear();

      // CplD length 4 split across two 2-DW buffers
      i_fifo_size = 24'd2;
      cpld(8'h06, 32'hE000_0000, 4, 4);
      idle();
      check_data("t2_data", 32'hE000_0000, 4);
      check("t2_cmpl", 64'(cmpl_n), 64'd1);
      check("t2_tag", 64'(o_cmpl_tag), 64'h06);
      check("t2_act_rise", 64'(act_rise), 64'd2);
      check("t2_act_cyc", 64'(act_n), 64'd4);
      check("t2_rdy_low", 64'(rdy_low), 64'd2);
      i_fifo_size = 24'd16;
      clear();

      // MWr32 then MWr64 single-DW register writes
      send(32'h4000_0001, 1'b0);
      send(32'h0000_000F, 1'b0);
      send(32'h0000_0010, 1'b0);
      send(32'hCAFE_F00D, 1'b1);
      idle();
      check("t3_reg_n", 64'(reg_n), 64'd1);
      check("t3_addr", 64'(o_reg_addr), 64'h10);
      check("t3_data", 64'(o_reg_data), 64'hCAFE_F00D);
      send(32'h6000_0001, 1'b0);
      send(32'h0000_000F, 1'b0);
      send(32'h0000_0000, 1'b0);
      send(32'h0000_0020, 1'b0);
      send(32'h1234_5678, 1'b1);
      idle();
      check("t3_reg_n64", 64'(reg_n), 64'd2);
      check("t3_addr64", 64'(o_reg_addr), 64'h20);
      check("t3_data64", 64'(o_reg_data), 64'h1234_5678);
      check("t3_no_fifo", 64'(stb_n + err_n + unsup_n), 64'd0);
      clear();

      // Cpl without data, status 1, tag 7, byte count 4
      send(32'h0A00_0000, 1'b0);
      send(32'h0000_2004, 1'b0);
      send(32'h0000_0700, 1'b1);
      idle();
      check("t4_cmpl", 64'(cmpl_n), 64'd1);
      check("t4_status", 64'(o_cmpl_status), 64'd1);
      check("t4_tag", 64'(o_cmpl_tag), 64'h07);
      check("t4_bc", 64'(o_cmpl_byte_cnt), 64'd4);
      check("t4_no_fifo", 64'(stb_n + act_n), 64'd0);
      clear();

      // MRd is unsupported; a CplD afterwards still parses
      send(32'h0000_0001, 1'b0);
      send(32'h0000_00FF, 1'b0);
      send(32'h0000_1000, 1'b1);
      idle();
      check("t5_unsup", 64'(unsup_n), 64'd1);
      check("t5_no_wr", 64'(stb_n + reg_n + err_n), 64'd0);
      cpld(8'h09, 32'hA000_0000, 2, 2);
      idle();
      check_data("t5_data", 32'hA000_0000, 2);
      check("t5_tag", 64'(o_cmpl_tag), 64'h09);
      clear();

      // CplD length 4 with last on data beat 2
      cpld(8'h0B, 32'hB000_0000, 4, 2);
      idle();
      check("t6_err", 64'(err_n), 64'd1);
      check("t6_cmpl", 64'(cmpl_n), 64'd0);
      check("t6_stb", 64'(stb_n), 64'd2);
      check("t6_act", 64'(o_fifo_act), 64'd0);
      check("t6_ready", 64'(o_axi_ingress_ready), 64'd1);
      check("t6_tag_held", 64'(o_cmpl_tag), 64'h09);
      clear();

      // reset in the middle of a CplD payload
      send(32'h4A00_0004, 1'b0);
      send(32'h0000_0010, 1'b0);
      send(32'h0000_0C00, 1'b0);
      send(32'hC000_0000, 1'b0);
      @(negedge clk);
      check("t7_act_before", 64'(o_fifo_act), 64'd1);
      i_axi_ingress_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("t7_ready", 64'(o_axi_ingress_ready), 64'd0);
      check("t7_act", 64'(o_fifo_act), 64'd0);
      check("t7_fdata", 64'(o_fifo_data), 64'd0);
      check("t7_tag", 64'(o_cmpl_tag), 64'd0);
      check("t7_regs", {o_reg_addr, o_reg_data}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("t7_ready_after", 64'(o_axi_ingress_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
